// File: rtl/wb_sequencer.sv
// wb_sequencer: writeback-stage sequencer driving an 8-bit register-file write port.
//
// Accepts one writeback request (source select + destination) when idle. It selects the source
// and issues registered register-file writes:
//   sel 0, 5..15 : ALU result,  one write
//   sel 1        : data memory, one write after MEM_LAT cycles of read latency
//   sel 2        : LUT pair,    LSW to dest, then MSW to dest+1 (mod 2^AW)
//   sel 3        : LUT MSW,     one write
//   sel 4        : immediate,   one write
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_valid / wb_ready        request handshake (ready only while idle)
//   wb_sel, wb_dest            source select, destination register
//   alu_in, lut_lsw_in,
//   lut_msw_in, imm_in         sources sampled at accept
//   mem_in                     sampled MEM_LAT cycles after accept
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//
// Optional feature, macro WB_FWD_EN: adds fwd_valid/fwd_addr/fwd_data, which copy the write
// port for decode-stage bypass, and fwd_pending, which is high while a write is still in flight.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a request; single-cycle sources are written from here
// MEM_WAIT | waiting out data-memory latency; writes mem_in when cnt hits 0
// PAIR_HI  | second half of a LUT pair load; writes captured MSW to dest+1

module wb_sequencer #(
   parameter int DW      = 8,
   parameter int AW      = 3,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [3:0]    wb_sel,
   input  logic [AW-1:0] wb_dest,
   input  logic [DW-1:0] alu_in,
   input  logic [DW-1:0] mem_in,
   input  logic [DW-1:0] lut_lsw_in,
   input  logic [DW-1:0] lut_msw_in,
   input  logic [DW-1:0] imm_in,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata
`ifdef WB_FWD_EN
   ,
   output logic          fwd_valid,
   output logic [AW-1:0] fwd_addr,
   output logic [DW-1:0] fwd_data,
   output logic          fwd_pending
`endif
);

   typedef enum logic [1:0] {IDLE, MEM_WAIT, PAIR_HI} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

   state_t        state, state_nxt;
   logic [2:0]    cnt, cnt_nxt;
   logic [AW-1:0] dest_hold, dest_hold_nxt;
   logic [DW-1:0] msw_hold, msw_hold_nxt;
   logic          we_nxt;
   logic [AW-1:0] waddr_nxt;
   logic [DW-1:0] wdata_nxt;

   assign wb_ready = (state == IDLE);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      dest_hold_nxt = dest_hold;
      msw_hold_nxt  = msw_hold;
      we_nxt        = 1'b0;
      waddr_nxt     = rf_waddr;
      wdata_nxt     = rf_wdata;
      case (state)
         IDLE: begin
            if (wb_valid) begin
               case (wb_sel)
                  4'd1: begin
                     state_nxt     = MEM_WAIT;
                     cnt_nxt       = CNT_LOAD;
                     dest_hold_nxt = wb_dest;
                  end
                  4'd2: begin
                     we_nxt        = 1'b1;
                     waddr_nxt     = wb_dest;
                     wdata_nxt     = lut_lsw_in;
                     msw_hold_nxt  = lut_msw_in;
                     // High half lands in the next register up, wrapping at the top.
                     dest_hold_nxt = wb_dest + AW'(1);
                     state_nxt     = PAIR_HI;
                  end
                  4'd3: begin
                     we_nxt    = 1'b1;
                     waddr_nxt = wb_dest;
                     wdata_nxt = lut_msw_in;
                  end
                  4'd4: begin
                     we_nxt    = 1'b1;
                     waddr_nxt = wb_dest;
                     wdata_nxt = imm_in;
                  end
                  default: begin
                     we_nxt    = 1'b1;
                     waddr_nxt = wb_dest;
                     wdata_nxt = alu_in;
                  end
               endcase
            end
         end
         MEM_WAIT: begin
            if (cnt == 3'd0) begin
               we_nxt    = 1'b1;
               waddr_nxt = dest_hold;
               wdata_nxt = mem_in;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         PAIR_HI: begin
            we_nxt    = 1'b1;
            waddr_nxt = dest_hold;
            wdata_nxt = msw_hold;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         dest_hold <= '0;
         msw_hold  <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         dest_hold <= dest_hold_nxt;
         msw_hold  <= msw_hold_nxt;
         rf_we     <= we_nxt;
         rf_waddr  <= waddr_nxt;
         rf_wdata  <= wdata_nxt;
      end
   end

`ifdef WB_FWD_EN
   assign fwd_valid   = rf_we;
   assign fwd_addr    = rf_waddr;
   assign fwd_data    = rf_wdata;
   assign fwd_pending = (state != IDLE);
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: two instances (MEM_LAT 1 and 3) share one stimulus stream. A directed
// table goes first, then random requests. A per-instance schedule of expected writes, indexed by
// cycle, is the reference; it is followed by a reset-abort check.

module tb_wb_sequencer;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int N  = 400;
   localparam int ND = 13;
   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   typedef struct packed {
      logic          v;
      logic [3:0]    sel;
      logic [AW-1:0] dest;
      logic [DW-1:0] alu;
      logic [DW-1:0] imm;
      logic [DW-1:0] lsw;
      logic [DW-1:0] msw;
   } req_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          wb_valid;
   logic [3:0]    wb_sel;
   logic [AW-1:0] wb_dest;
   logic [DW-1:0] alu_in, mem_in, lut_lsw_in, lut_msw_in, imm_in;

   logic          wb_ready [2];
   logic          rf_we    [2];
   logic [AW-1:0] rf_waddr [2];
   logic [DW-1:0] rf_wdata [2];
`ifdef WB_FWD_EN
   logic          fwd_valid   [2];
   logic [AW-1:0] fwd_addr    [2];
   logic [DW-1:0] fwd_data    [2];
   logic          fwd_pending [2];
`endif

   wb_sequencer #(.DW(DW), .AW(AW), .MEM_LAT(LAT0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready[0]),
      .wb_sel(wb_sel), .wb_dest(wb_dest), .alu_in(alu_in), .mem_in(mem_in),
      .lut_lsw_in(lut_lsw_in), .lut_msw_in(lut_msw_in), .imm_in(imm_in),
      .rf_we(rf_we[0]), .rf_waddr(rf_waddr[0]), .rf_wdata(rf_wdata[0])
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid[0]), .fwd_addr(fwd_addr[0]), .fwd_data(fwd_data[0]),
      .fwd_pending(fwd_pending[0])
`endif
   );

   wb_sequencer #(.DW(DW), .AW(AW), .MEM_LAT(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready[1]),
      .wb_sel(wb_sel), .wb_dest(wb_dest), .alu_in(alu_in), .mem_in(mem_in),
      .lut_lsw_in(lut_lsw_in), .lut_msw_in(lut_msw_in), .imm_in(imm_in),
      .rf_we(rf_we[1]), .rf_waddr(rf_waddr[1]), .rf_wdata(rf_wdata[1])
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid[1]), .fwd_addr(fwd_addr[1]), .fwd_data(fwd_data[1]),
      .fwd_pending(fwd_pending[1])
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: expected writes per instance per cycle, plus when each instance is free again.
   bit            exp_we   [2][N+8];
   logic [AW-1:0] exp_addr [2][N+8];
   logic [DW-1:0] exp_data [2][N+8];
   logic [DW-1:0] mem_data [N+8];
   int            busy_until [2];
   logic [AW-1:0] last_addr  [2];
   logic [DW-1:0] last_data  [2];
   int            lat [2];
   req_t          dir [ND];

   task automatic schedule(input int i, input int t, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_we[i][t]   = 1'b1;
      exp_addr[i][t] = a;
      exp_data[i][t] = d;
   endtask

   initial begin
      req_t r;
      logic [AW-1:0] a_hi;
      lat[0] = LAT0;
      lat[1] = LAT1;
      dir[0]  = '{1'b1, 4'd0, 3'd2, 8'h3C, 8'h00, 8'h00, 8'h00};
      dir[1]  = '{1'b1, 4'd4, 3'd5, 8'h00, 8'hA5, 8'h00, 8'h00};
      dir[2]  = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      dir[3]  = '{1'b1, 4'd1, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00};
      dir[4]  = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      dir[5]  = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      dir[6]  = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      dir[7]  = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      dir[8]  = '{1'b1, 4'd2, 3'd7, 8'h00, 8'h00, 8'h34, 8'h12};
      dir[9]  = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF};
      dir[10] = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF};
      dir[11] = '{1'b1, 4'd9, 3'd6, 8'h5A, 8'h00, 8'h00, 8'h00};
      dir[12] = '{1'b0, 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int c = 0; c < N + 8; c++) begin
         mem_data[c] = (c < ND) ? 8'h00 : DW'($urandom);
         for (int i = 0; i < 2; i++) begin
            exp_we[i][c]   = 1'b0;
            exp_addr[i][c] = '0;
            exp_data[i][c] = '0;
         end
      end
      mem_data[4] = 8'h77;
      for (int i = 0; i < 2; i++) begin
         busy_until[i] = 0;
         last_addr[i]  = '0;
         last_data[i]  = '0;
      end

      // Reset with a request pending: nothing may be written.
      wb_valid = 1'b1; wb_sel = 4'd0; wb_dest = 3'd5;
      alu_in = 8'hEE; mem_in = 8'h00; lut_lsw_in = 8'h00; lut_msw_in = 8'h00; imm_in = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_we",    32'(rf_we[i]),    32'd0);
         check_eq("rst_waddr", 32'(rf_waddr[i]), 32'd0);
         check_eq("rst_wdata", 32'(rf_wdata[i]), 32'd0);
      end
      rst_n = 1'b1;
      wb_valid = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) check_eq("rst_ready", 32'(wb_ready[i]), 32'd1);

      for (int c = 0; c < N; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (exp_we[i][c]) begin
               last_addr[i] = exp_addr[i][c];
               last_data[i] = exp_data[i][c];
            end
            check_eq("we",    32'(rf_we[i]),    32'(exp_we[i][c]));
            check_eq("waddr", 32'(rf_waddr[i]), 32'(last_addr[i]));
            check_eq("wdata", 32'(rf_wdata[i]), 32'(last_data[i]));
            check_eq("ready", 32'(wb_ready[i]), 32'(c >= busy_until[i]));
`ifdef WB_FWD_EN
            check_eq("fwd_valid",   32'(fwd_valid[i]),   32'(exp_we[i][c]));
            check_eq("fwd_addr",    32'(fwd_addr[i]),    32'(last_addr[i]));
            check_eq("fwd_data",    32'(fwd_data[i]),    32'(last_data[i]));
            check_eq("fwd_pending", 32'(fwd_pending[i]), 32'(c < busy_until[i]));
`endif
         end

         if (c < ND) begin
            r = dir[c];
         end else begin
            r.v    = ($urandom_range(0, 3) != 0) && (c < N - 10);
            case ($urandom_range(0, 5))
               0:       r.sel = 4'd1;
               1:       r.sel = 4'd2;
               default: r.sel = 4'($urandom_range(0, 15));
            endcase
            r.dest = AW'($urandom);
            r.alu  = DW'($urandom);
            r.imm  = DW'($urandom);
            r.lsw  = DW'($urandom);
            r.msw  = DW'($urandom);
         end
         wb_valid = r.v; wb_sel = r.sel; wb_dest = r.dest;
         alu_in = r.alu; imm_in = r.imm; lut_lsw_in = r.lsw; lut_msw_in = r.msw;
         mem_in = mem_data[c];

         for (int i = 0; i < 2; i++) begin
            if (r.v && c >= busy_until[i]) begin
               if (r.sel == 4'd1) begin
                  schedule(i, c + lat[i] + 1, r.dest, mem_data[c + lat[i]]);
                  busy_until[i] = c + lat[i] + 1;
               end else if (r.sel == 4'd2) begin
                  a_hi = r.dest + 3'd1;
                  schedule(i, c + 1, r.dest, r.lsw);
                  schedule(i, c + 2, a_hi, r.msw);
                  busy_until[i] = c + 2;
               end else begin
                  schedule(i, c + 1, r.dest,
                           (r.sel == 4'd3) ? r.msw : (r.sel == 4'd4) ? r.imm : r.alu);
                  busy_until[i] = c + 1;
               end
            end
         end
         @(posedge clk);
         @(negedge clk);
      end

      // Abort a LUT pair after its first write: the dest+1 write must never appear.
      wb_valid = 1'b1; wb_sel = 4'd2; wb_dest = 3'd3; lut_lsw_in = 8'h11; lut_msw_in = 8'h22;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      check_eq("abort_first_we",   32'(rf_we[0]),    32'd1);
      check_eq("abort_first_addr", 32'(rf_waddr[0]), 32'd3);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq("abort_we",    32'(rf_we[i]),    32'd0);
         check_eq("abort_waddr", 32'(rf_waddr[i]), 32'd0);
         check_eq("abort_wdata", 32'(rf_wdata[i]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check_eq("post_abort_we",    32'(rf_we[i]),    32'd0);
            check_eq("post_abort_waddr", 32'(rf_waddr[i]), 32'd0);
            check_eq("post_abort_ready", 32'(wb_ready[i]), 32'd1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
